// File: rtl/piece_move_scheduler.sv
// Game-step sequencer in front of the falling-piece center tracker.
// Turns the held keycode into one-cycle move requests (with left/right
// auto-repeat), generates gravity drop steps and runs the
// spawn/fall/lock/clear/game-over sequence.
//
// Ports:
//   Clk             in  1  system clock, posedge
//   reset_n         in  1  asynchronous active-low reset
//   start           in  1  level; rising edge starts a game (IDLE/OVER)
//   keycode         in  8  held keycode, 00 none, 04 L, 07 R, 1A rot,
//                          06 swap, 16 soft drop
//   can_shift_left  in  1  piece fits one column left
//   can_shift_right in  1  piece fits one column right
//   can_rotate      in  1  rotated piece fits
//   can_swap        in  1  hold/swap target fits
//   can_drop        in  1  piece fits one row lower
//   spawn_blocked   in  1  new piece overlaps board at spawn
//   clear_done      in  1  line clear finished (pulse)
//   state           out 3  000 hold, 001 drop, 010 spawn, 011 lock,
//                          100 clear, 111 over
//   move_key        out 8  accepted move keycode for one cycle, else 00
//   lock_pulse      out 1  piece written to board
//   swap_used       out 1  swap already used for the current piece
//   game_over       out 1  high while in OVER
module piece_move_scheduler #(
  parameter int DROP_PERIOD = 25_000_000,
  parameter int SOFT_PERIOD = 2_500_000,
  parameter int DAS_DELAY   = 8_000_000,
  parameter int ARR_PERIOD  = 2_000_000,
  parameter int LOCK_DELAY  = 25_000_000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] keycode,
  input  logic       can_shift_left,
  input  logic       can_shift_right,
  input  logic       can_rotate,
  input  logic       can_swap,
  input  logic       can_drop,
  input  logic       spawn_blocked,
  input  logic       clear_done,
  output logic [2:0] state,
  output logic [7:0] move_key,
  output logic       lock_pulse,
  output logic       swap_used,
  output logic       game_over
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(
    max2(DROP_PERIOD, SOFT_PERIOD),
    max2(max2(DAS_DELAY, ARR_PERIOD), LOCK_DELAY));
  localparam int CW = $clog2(MAXP) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DROP_M1 = cnt_t'(DROP_PERIOD - 1);
  localparam cnt_t SOFT_M1 = cnt_t'(SOFT_PERIOD - 1);
  localparam cnt_t DAS_C   = cnt_t'(DAS_DELAY);
  localparam cnt_t ARR_M1  = cnt_t'(ARR_PERIOD - 1);
  localparam cnt_t LOCK_M1 = cnt_t'(LOCK_DELAY - 1);

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_L    = 8'h04;
  localparam logic [7:0] KEY_R    = 8'h07;
  localparam logic [7:0] KEY_ROT  = 8'h1A;
  localparam logic [7:0] KEY_SWAP = 8'h06;
  localparam logic [7:0] KEY_SOFT = 8'h16;

  localparam logic [2:0] ST_HOLD  = 3'b000;
  localparam logic [2:0] ST_DROP  = 3'b001;
  localparam logic [2:0] ST_SPAWN = 3'b010;
  localparam logic [2:0] ST_LOCK  = 3'b011;
  localparam logic [2:0] ST_CLEAR = 3'b100;
  localparam logic [2:0] ST_OVER  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_LOCK,
    S_CLEAR,
    S_OVER
  } fsm_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  fsm_t       r_fsm;
  logic       r_start_d;
  logic [7:0] r_prev_key;
  cnt_t       r_grav;
  cnt_t       r_lock;
  cnt_t       r_das;
  cnt_t       r_arr;
  logic       r_pend;
  logic       r_swap;
  logic [2:0] r_state;
  logic [7:0] r_move;
  logic       r_lock_p;
  logic       r_over;

  fsm_t       w_fsm_nxt;
  cnt_t       w_grav_nxt;
  cnt_t       w_lock_nxt;
  cnt_t       w_das_nxt;
  cnt_t       w_arr_nxt;
  logic       w_pend_nxt;
  logic       w_swap_nxt;
  logic [2:0] w_state_nxt;
  logic       w_drop;
  logic       w_lock_fire;

  logic       w_start_rise;
  logic       w_active;
  logic       w_new_press;
  logic       w_is_shift;
  logic       w_held_shift;
  logic       w_repeat;
  logic       w_fits;
  logic       w_move;
  logic       w_swap_ok;
  logic       w_due;
  cnt_t       w_period_m1;

  assign w_start_rise = start & ~r_start_d;
  assign w_active     = (r_fsm == S_FALL) || (r_fsm == S_LOCK);
  assign w_new_press  = (keycode != r_prev_key) &&
                        (keycode != KEY_NONE);
  assign w_is_shift   = (keycode == KEY_L) || (keycode == KEY_R);
  assign w_held_shift = (keycode == r_prev_key) && w_is_shift;
  assign w_repeat     = w_held_shift && (r_das >= DAS_C) &&
                        (r_arr == '0);

  // Fit check per key; swap is only allowed once per piece.
  always_comb begin
    w_fits = 1'b0;
    unique case (1'b1)
      (keycode == KEY_L):    w_fits = can_shift_left;
      (keycode == KEY_R):    w_fits = can_shift_right;
      (keycode == KEY_ROT):  w_fits = can_rotate;
      (keycode == KEY_SWAP): w_fits = can_swap & ~r_swap;
      default:               w_fits = 1'b0;
    endcase
  end

  // Only fresh presses of any key, or repeats of shift keys, request.
  assign w_move    = w_active && (w_new_press || w_repeat) && w_fits;
  assign w_swap_ok = w_move && (keycode == KEY_SWAP);

  assign w_period_m1 = (keycode == KEY_SOFT) ? SOFT_M1 : DROP_M1;
  assign w_due       = r_pend || (r_grav >= w_period_m1);

  // DAS counts held cycles since the press; once it has elapsed the
  // ARR phase counter fires a repeat each time it wraps to zero.
  always_comb begin
    w_das_nxt = '0;
    w_arr_nxt = '0;
    if (r_fsm != S_SPAWN) begin
      if (w_new_press) begin
        w_das_nxt = cnt_t'(1);
      end else if (w_held_shift) begin
        w_das_nxt = (r_das < DAS_C) ? sat_inc(r_das) : r_das;
        if (r_das >= DAS_C) begin
          w_arr_nxt = (r_arr >= ARR_M1) ? '0 : sat_inc(r_arr);
        end
      end
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_grav_nxt  = r_grav;
    w_lock_nxt  = r_lock;
    w_pend_nxt  = r_pend;
    w_swap_nxt  = r_swap;
    w_drop      = 1'b0;
    w_lock_fire = 1'b0;

    unique case (r_fsm)
      S_IDLE: begin
        if (w_start_rise) begin
          w_fsm_nxt = S_SPAWN;
        end
      end
      S_SPAWN: begin
        w_grav_nxt = '0;
        w_lock_nxt = '0;
        w_pend_nxt = 1'b0;
        w_fsm_nxt  = spawn_blocked ? S_OVER : S_FALL;
      end
      S_FALL: begin
        if (w_due) begin
          w_grav_nxt = '0;
          if (w_move) begin
            // Move wins this cycle; the drop retries next cycle.
            w_pend_nxt = 1'b1;
          end else if (can_drop) begin
            w_drop     = 1'b1;
            w_pend_nxt = 1'b0;
          end else begin
            w_pend_nxt = 1'b0;
            w_lock_nxt = '0;
            w_fsm_nxt  = S_LOCK;
          end
        end else begin
          w_grav_nxt = sat_inc(r_grav);
        end
      end
      S_LOCK: begin
        if (can_drop) begin
          w_grav_nxt = '0;
          w_fsm_nxt  = S_FALL;
        end else if (r_lock >= LOCK_M1) begin
          w_lock_fire = 1'b1;
          w_swap_nxt  = 1'b0;
          w_fsm_nxt   = S_CLEAR;
        end else begin
          w_lock_nxt = sat_inc(r_lock);
        end
      end
      S_CLEAR: begin
        if (clear_done) begin
          w_fsm_nxt = S_SPAWN;
        end
      end
      S_OVER: begin
        if (w_start_rise) begin
          w_swap_nxt = 1'b0;
          w_fsm_nxt  = S_SPAWN;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase

    // A swap recenters the piece, so gravity restarts from zero.
    if (w_swap_ok) begin
      w_grav_nxt = '0;
      if (!w_lock_fire) begin
        w_swap_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = ST_HOLD;
    unique case (w_fsm_nxt)
      S_IDLE:  w_state_nxt = ST_HOLD;
      S_SPAWN: w_state_nxt = ST_SPAWN;
      S_FALL:  w_state_nxt = w_drop ? ST_DROP : ST_HOLD;
      S_LOCK:  w_state_nxt = ST_LOCK;
      S_CLEAR: w_state_nxt = ST_CLEAR;
      S_OVER:  w_state_nxt = ST_OVER;
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm      <= S_IDLE;
      r_start_d  <= 1'b0;
      r_prev_key <= KEY_NONE;
      r_grav     <= '0;
      r_lock     <= '0;
      r_das      <= '0;
      r_arr      <= '0;
      r_pend     <= 1'b0;
      r_swap     <= 1'b0;
      r_state    <= ST_HOLD;
      r_move     <= KEY_NONE;
      r_lock_p   <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_start_d  <= start;
      r_prev_key <= keycode;
      r_grav     <= w_grav_nxt;
      r_lock     <= w_lock_nxt;
      r_das      <= w_das_nxt;
      r_arr      <= w_arr_nxt;
      r_pend     <= w_pend_nxt;
      r_swap     <= w_swap_nxt;
      r_state    <= w_state_nxt;
      r_move     <= w_move ? keycode : KEY_NONE;
      r_lock_p   <= w_lock_fire;
      r_over     <= (w_fsm_nxt == S_OVER);
    end
  end

  assign state      = r_state;
  assign move_key   = r_move;
  assign lock_pulse = r_lock_p;
  assign swap_used  = r_swap;
  assign game_over  = r_over;

endmodule
